// File: rtl/ofmap_write_packer_pkg.sv
// Shared widths, FSM encoding and default map size for the ofmap write packer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ofmap_write_packer_pkg;
  localparam int DRAM_DATA_W       = 64;
  localparam int PIX_W             = 8;
  localparam int PIX_PER_WORD      = 8;
  localparam int DEFAULT_NUM_WORDS = 151;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/packer_fifo.sv
// Small FIFO holding packed 64-bit words between the packer and the DRAM port.
// Latency: a pushed word is visible at head_dat the cycle after the push.
// Backpressure: push ignored when full unless a pop happens the same cycle.
module packer_fifo #(
  parameter int AW = 2,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] head_dat,
  output logic          full,
  output logic          empty
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign head_dat = mem_q[rd_ptr_q];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  // Pointer and occupancy update; clear wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
      else if (do_pop && !do_push) cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  // Control state flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= push_dat;
  end
endmodule

// File: rtl/ofmap_write_packer.sv
// Packs 8-bit pooled pixels into 64-bit words and writes them to consecutive DRAM addresses.
// Latency: 8th pixel accepted at edge E -> DRAMwriteEn high after edge E+1 (FIFO empty, no stall).
// Backpressure: dram_stall holds the FIFO; pix_ready drops only for a lane-7 pixel while the FIFO is full.
module ofmap_write_packer
  import ofmap_write_packer_pkg::*;
#(
  parameter int NUM_WORDS = DEFAULT_NUM_WORDS,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 10,
  parameter int FIFO_AW   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   pix_valid,
  input  logic [PIX_W-1:0]       pix_data,
  output logic                   pix_ready,
  input  logic                   flush,
  input  logic                   dram_stall,
  output logic                   DRAMwriteEn,
  output logic [ADDR_W-1:0]      DRAMwriteAddr,
  output logic [DRAM_DATA_W-1:0] DRAMwriteData,
  output logic                   done
);
  localparam int                CNT_W     = $clog2(NUM_WORDS + 1);
  localparam int                IDX_W     = $clog2(PIX_PER_WORD);
  localparam logic [IDX_W-1:0]  LAST_LANE = IDX_W'(PIX_PER_WORD - 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(NUM_WORDS - 1);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DRAM_DATA_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]       push_cnt_q, push_cnt_d;
  logic [CNT_W-1:0]       wr_cnt_q, wr_cnt_d;
  logic                   en_q, en_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DRAM_DATA_W-1:0] data_q, data_d;
  logic                   done_q, done_d;

  logic                   in_pack, accept, lane7, flush_req;
  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DRAM_DATA_W-1:0] packed_word, fifo_head;

  assign in_pack   = (state_q == ST_PACK);
  assign pix_ready = in_pack && !(fifo_full && idx_q == LAST_LANE);
  assign accept    = pix_valid && pix_ready;
  assign lane7     = accept && (idx_q == LAST_LANE);
  // A flush with an empty assembly word is a no-op unless a pixel lands in it this cycle.
  assign flush_req = in_pack && flush && (idx_q != '0 || accept);
  assign fifo_pop  = !start && !fifo_empty && !dram_stall;
  assign fifo_push = !start && (lane7 || (flush_req && (!fifo_full || fifo_pop)));

  // Merge the incoming pixel into its lane; lanes not yet written stay zero.
  always_comb begin
    packed_word = buf_q;
    if (accept) packed_word[{idx_q, 3'b000} +: PIX_W] = pix_data;
  end

  // Next-state for packing, counters, FSM and the registered DRAM port.
  always_comb begin
    idx_d      = idx_q;
    buf_d      = buf_q;
    push_cnt_d = push_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    state_d    = state_q;
    en_d       = fifo_pop;
    addr_d     = addr_q;
    data_d     = data_q;
    done_d     = (state_q == ST_DONE) && !start;
    if (start) begin
      idx_d      = '0;
      buf_d      = '0;
      push_cnt_d = '0;
      wr_cnt_d   = '0;
      addr_d     = BASE;
      state_d    = ST_PACK;
    end else begin
      if (fifo_push) begin
        idx_d      = '0;
        buf_d      = '0;
        push_cnt_d = push_cnt_q + CNT_W'(1);
      end else if (accept) begin
        idx_d = idx_q + IDX_W'(1);
        buf_d = packed_word;
      end
      if (fifo_pop) begin
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
        addr_d   = BASE + ADDR_W'(wr_cnt_q);
        data_d   = fifo_head;
      end
      case (state_q)
        ST_PACK:  if (fifo_push && push_cnt_q == LAST_CNT) state_d = ST_DRAIN;
        ST_DRAIN: if (fifo_pop && wr_cnt_q == LAST_CNT)    state_d = ST_DONE;
        default:  state_d = state_q;
      endcase
    end
  end

  // All control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      buf_q      <= '0;
      push_cnt_q <= '0;
      wr_cnt_q   <= '0;
      en_q       <= 1'b0;
      addr_q     <= BASE;
      data_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      buf_q      <= buf_d;
      push_cnt_q <= push_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      en_q       <= en_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      done_q     <= done_d;
    end
  end

  assign DRAMwriteEn   = en_q;
  assign DRAMwriteAddr = addr_q;
  assign DRAMwriteData = data_q;
  assign done          = done_q;

  packer_fifo #(
    .AW (FIFO_AW),
    .DW (DRAM_DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start),
    .push     (fifo_push),
    .push_dat (packed_word),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );
endmodule
